vram_arbiter: RTL and testbench

- Time-shares the single 16-bit video RAM between the 68010 CPU and two video fetch engines: playfield (PF) and motion object (MO).
- Sits between the address decoder's VRAM_b select and the VRAM chips, and replaces the per-slot VRAC2 latch.
- Generates VRDTACK_b to the CPU, drives the VRAM address/data/strobes, and returns read data to each requester.
- Fixed priority PF > MO > CPU, with a starvation guard for the CPU.

---
 rtl/vram_arb_pkg.sv | 20 ++
 rtl/vram_arbiter_if.sv | 50 +++++
 rtl/vram_arb_pick.sv | 35 +++
 rtl/vram_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_arb_pkg;

    // Width of the access-cycle counter and of the starvation counter.
    localparam int CNT_W = 4;

    // Arbiter sequencing state.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Which requester owns the VRAM for the current access.
    typedef enum logic [1:0] {
        OWN_PF  = 2'd0,
        OWN_MO  = 2'd1,
        OWN_CPU = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundles the CPU, video-fetch and VRAM-chip signals around the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 12
);
    // CPU side
    logic              AS_b;
    logic              VRAM_b;
    logic              BR_W_b;
    logic              UDS_b;
    logic              LDS_b;
    logic [ADDR_W-1:0] CPU_A;
    logic [15:0]       CPU_D_in;
    logic [15:0]       CPU_D_out;
    logic              VRDTACK_b;

    // Video fetch side
    logic              PF_REQ;
    logic              MO_REQ;
    logic [ADDR_W-1:0] PF_A;
    logic [ADDR_W-1:0] MO_A;
    logic              PF_ACK;
    logic              MO_ACK;
    logic              PF_VALID;
    logic              MO_VALID;
    logic [15:0]       V_DATA;

    // VRAM chip side
    logic [ADDR_W-1:0] VA;
    logic [15:0]       VD_out;
    logic [15:0]       VD_in;
    logic              VCS_b;
    logic              VOE_b;
    logic [1:0]        VWE_b;

    modport slave (
        input  AS_b, VRAM_b, BR_W_b, UDS_b, LDS_b, CPU_A, CPU_D_in,
        input  PF_REQ, MO_REQ, PF_A, MO_A, VD_in,
        output CPU_D_out, VRDTACK_b, PF_ACK, MO_ACK, PF_VALID, MO_VALID,
        output V_DATA, VA, VD_out, VCS_b, VOE_b, VWE_b
    );

    modport master (
        output AS_b, VRAM_b, BR_W_b, UDS_b, LDS_b, CPU_A, CPU_D_in,
        output PF_REQ, MO_REQ, PF_A, MO_A, VD_in,
        input  CPU_D_out, VRDTACK_b, PF_ACK, MO_ACK, PF_VALID, MO_VALID,
        input  V_DATA, VA, VD_out, VCS_b, VOE_b, VWE_b
    );

endinterface

// File: rtl/vram_arb_pick.sv
// Winner selection for one grant point: PF > MO > CPU, except that a CPU
// request that has already been passed over MAX_STALL times jumps the queue.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int MAX_STALL = 2
) (
    input  logic             pfReq_i,
    input  logic             moReq_i,
    input  logic             cpuPend_i,
    input  logic [CNT_W-1:0] stall_i,
    output owner_t           owner_o,
    output logic             valid_o
);

    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

    // Priority chain with the starvation override checked first.
    always_comb begin
        owner_o = OWN_PF;
        valid_o = 1'b1;
        if (cpuPend_i && (stall_i >= STALL_LIM)) begin
            owner_o = OWN_CPU;
        end else if (pfReq_i) begin
            owner_o = OWN_PF;
        end else if (moReq_i) begin
            owner_o = OWN_MO;
        end else if (cpuPend_i) begin
            owner_o = OWN_CPU;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-shares the 16-bit video RAM between the CPU and the PF/MO fetch engines.
// Each access is a fixed ACC_CYC clocks; a new owner is chosen on the edge that
// completes the previous access, so back-to-back accesses have no idle gap.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int ACC_CYC   = 4,
    parameter int MAX_STALL = 2
) (
    input  logic           MCKR,
    input  logic           SYSRES,
    vram_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              uds_q, uds_d;
    logic              lds_q, lds_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ackPf_q, ackPf_d;
    logic              ackMo_q, ackMo_d;
    logic              validPf_q, validPf_d;
    logic              validMo_q, validMo_d;
    logic [15:0]       vData_q, vData_d;
    logic [15:0]       cpuDout_q, cpuDout_d;
    logic              dtackB_q, dtackB_d;
    logic              cpuDone_q, cpuDone_d;
    logic              aborted_q, aborted_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic   accessing;
    logic   lastCyc;
    logic   grantPt;
    logic   cpuPend;
    logic   cpuReq;
    owner_t pickOwner;
    logic   pickValid;

    assign accessing = (state_q == ACCESS);
    assign lastCyc   = accessing && (cnt_q == LAST_CNT);
    assign grantPt   = !accessing || lastCyc;
    assign cpuPend   = !bus.AS_b && !bus.VRAM_b && !cpuDone_q;
    // The CPU cycle being serviced must not win the grant point that ends it,
    // otherwise one AS_b cycle would be issued to the VRAM twice.
    assign cpuReq    = cpuPend && !(accessing && (owner_q == OWN_CPU));

    vram_arb_pick #(
        .MAX_STALL (MAX_STALL)
    ) u_pick (
        .pfReq_i   (bus.PF_REQ),
        .moReq_i   (bus.MO_REQ),
        .cpuPend_i (cpuReq),
        .stall_i   (stall_q),
        .owner_o   (pickOwner),
        .valid_o   (pickValid)
    );

    // Next-state logic: completion, DTACK release, grant and starvation count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        wdata_d   = wdata_q;
        ackPf_d   = 1'b0;
        ackMo_d   = 1'b0;
        validPf_d = 1'b0;
        validMo_d = 1'b0;
        vData_d   = vData_q;
        cpuDout_d = cpuDout_q;
        dtackB_d  = dtackB_q;
        cpuDone_d = cpuDone_q;
        aborted_d = aborted_q;
        stall_d   = stall_q;

        if (accessing && (owner_q == OWN_CPU) && bus.AS_b) begin
            aborted_d = 1'b1;
        end

        if (lastCyc) begin
            case (owner_q)
                OWN_PF: begin
                    validPf_d = 1'b1;
                    vData_d   = bus.VD_in;
                end
                OWN_MO: begin
                    validMo_d = 1'b1;
                    vData_d   = bus.VD_in;
                end
                OWN_CPU: begin
                    if (!aborted_q && !bus.AS_b) begin
                        dtackB_d  = 1'b0;
                        cpuDone_d = 1'b1;
                        if (rd_q) begin
                            cpuDout_d = bus.VD_in;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (cpuDone_q && bus.AS_b) begin
            dtackB_d  = 1'b1;
            cpuDone_d = 1'b0;
        end

        if (grantPt) begin
            cnt_d = '0;
            if (pickValid) begin
                state_d   = ACCESS;
                owner_d   = pickOwner;
                aborted_d = 1'b0;
                case (pickOwner)
                    OWN_PF: begin
                        addr_d  = bus.PF_A;
                        rd_d    = 1'b1;
                        uds_d   = 1'b0;
                        lds_d   = 1'b0;
                        ackPf_d = 1'b1;
                    end
                    OWN_MO: begin
                        addr_d  = bus.MO_A;
                        rd_d    = 1'b1;
                        uds_d   = 1'b0;
                        lds_d   = 1'b0;
                        ackMo_d = 1'b1;
                    end
                    OWN_CPU: begin
                        addr_d  = bus.CPU_A;
                        rd_d    = bus.BR_W_b;
                        uds_d   = bus.UDS_b;
                        lds_d   = bus.LDS_b;
                        wdata_d = bus.CPU_D_in;
                    end
                    default: ;
                endcase
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_q + 4'd1;
        end

        if (!cpuPend) begin
            stall_d = '0;
        end else if (grantPt && pickValid) begin
            if (pickOwner == OWN_CPU) begin
                stall_d = '0;
            end else if (stall_q != STALL_MAX) begin
                stall_d = stall_q + 4'd1;
            end
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge MCKR or posedge SYSRES) begin
        if (SYSRES) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_PF;
            addr_q    <= '0;
            rd_q      <= 1'b1;
            uds_q     <= 1'b1;
            lds_q     <= 1'b1;
            wdata_q   <= '0;
            ackPf_q   <= 1'b0;
            ackMo_q   <= 1'b0;
            validPf_q <= 1'b0;
            validMo_q <= 1'b0;
            vData_q   <= '0;
            cpuDout_q <= '0;
            dtackB_q  <= 1'b1;
            cpuDone_q <= 1'b0;
            aborted_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            wdata_q   <= wdata_d;
            ackPf_q   <= ackPf_d;
            ackMo_q   <= ackMo_d;
            validPf_q <= validPf_d;
            validMo_q <= validMo_d;
            vData_q   <= vData_d;
            cpuDout_q <= cpuDout_d;
            dtackB_q  <= dtackB_d;
            cpuDone_q <= cpuDone_d;
            aborted_q <= aborted_d;
            stall_q   <= stall_d;
        end
    end

    // Strobes decode straight from registered state so reset drops them at once.
    // Write enables release one cycle early to give address/data hold time.
    assign bus.VCS_b     = !accessing;
    assign bus.VOE_b     = !(accessing && rd_q);
    assign bus.VWE_b     = (accessing && !rd_q && !lastCyc) ? {uds_q, lds_q} : 2'b11;
    assign bus.VA        = addr_q;
    assign bus.VD_out    = wdata_q;
    assign bus.CPU_D_out = cpuDout_q;
    assign bus.VRDTACK_b = dtackB_q;
    assign bus.PF_ACK    = ackPf_q;
    assign bus.MO_ACK    = ackMo_q;
    assign bus.PF_VALID  = validPf_q;
    assign bus.MO_VALID  = validMo_q;
    assign bus.V_DATA    = vData_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (ACC_CYC = 4, MAX_STALL = 2).
module tb_vram_arbiter;

    logic MCKR;
    logic SYSRES;
    int   checks;
    int   failures;

    vram_arbiter_if #(.ADDR_W(12)) bus ();

    vram_arbiter #(
        .ADDR_W    (12),
        .ACC_CYC   (4),
        .MAX_STALL (2)
    ) dut (
        .MCKR   (MCKR),
        .SYSRES (SYSRES),
        .bus    (bus)
    );

    // Free-running 100 MHz-style clock, rising edges at 5, 15, 25 ...
    initial begin
        MCKR = 1'b0;
        forever #5 MCKR = ~MCKR;
    end

    // Advance past the next rising edge and settle before sampling.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge MCKR);
            #1;
        end
    endtask

    // Drive the CPU side of the bus.
    task automatic applyStimulus(input logic asB, input logic vramB, input logic rwB,
                                 input logic udsB, input logic ldsB,
                                 input logic [11:0] addr, input logic [15:0] wdata);
        bus.AS_b     = asB;
        bus.VRAM_b   = vramB;
        bus.BR_W_b   = rwB;
        bus.UDS_b    = udsB;
        bus.LDS_b    = ldsB;
        bus.CPU_A    = addr;
        bus.CPU_D_in = wdata;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        SYSRES   = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000);
        bus.PF_REQ = 1'b0;
        bus.MO_REQ = 1'b0;
        bus.PF_A   = 12'h000;
        bus.MO_A   = 12'h000;
        bus.VD_in  = 16'h0000;

        // ---------------- reset values ----------------
        $display("[TB] reset values");
        tick(2);
        checkOutput("rst_VCS_b",     bus.VCS_b,     1);
        checkOutput("rst_VOE_b",     bus.VOE_b,     1);
        checkOutput("rst_VWE_b",     bus.VWE_b,     3);
        checkOutput("rst_VRDTACK_b", bus.VRDTACK_b, 1);
        checkOutput("rst_PF_ACK",    bus.PF_ACK,    0);
        checkOutput("rst_MO_ACK",    bus.MO_ACK,    0);
        checkOutput("rst_PF_VALID",  bus.PF_VALID,  0);
        checkOutput("rst_MO_VALID",  bus.MO_VALID,  0);
        checkOutput("rst_VA",        bus.VA,        0);
        checkOutput("rst_VD_out",    bus.VD_out,    0);
        checkOutput("rst_CPU_D_out", bus.CPU_D_out, 0);
        checkOutput("rst_V_DATA",    bus.V_DATA,    0);
        SYSRES = 1'b0;
        tick();
        checkOutput("idle_VCS_b", bus.VCS_b, 1);

        // ---------------- CPU read alone ----------------
        $display("[TB] CPU read");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 16'h0000);
        bus.VD_in = 16'hBEEF;
        tick();
        checkOutput("rd_VA",      bus.VA,        12'h123);
        checkOutput("rd_VCS_b",   bus.VCS_b,     0);
        checkOutput("rd_VOE_b",   bus.VOE_b,     0);
        checkOutput("rd_VWE_b",   bus.VWE_b,     3);
        checkOutput("rd_dtack_n", bus.VRDTACK_b, 1);
        tick(3);
        checkOutput("rd_dtack_n3", bus.VRDTACK_b, 1);
        checkOutput("rd_VOE_b3",   bus.VOE_b,     0);
        tick();
        checkOutput("rd_CPU_D_out", bus.CPU_D_out, 16'hBEEF);
        checkOutput("rd_dtack_n4",  bus.VRDTACK_b, 0);
        checkOutput("rd_VCS_b4",    bus.VCS_b,     1);
        tick();
        checkOutput("rd_dtack_hold", bus.VRDTACK_b, 0);
        checkOutput("rd_no_reissue", bus.VCS_b,     1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 16'h0000);
        tick();
        checkOutput("rd_dtack_rel", bus.VRDTACK_b, 1);

        // ---------------- CPU byte write ----------------
        $display("[TB] CPU byte write");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h045, 16'h00A5);
        tick();
        checkOutput("wr_VD_out", bus.VD_out, 16'h00A5);
        checkOutput("wr_VOE_b",  bus.VOE_b,  1);
        checkOutput("wr_VA",     bus.VA,     12'h045);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wr_VWE_b_c%0d", i), bus.VWE_b, (i < 3) ? 2 : 3);
            checkOutput($sformatf("wr_VCS_b_c%0d", i), bus.VCS_b, 0);
            tick();
        end
        checkOutput("wr_dtack_n4", bus.VRDTACK_b, 0);
        checkOutput("wr_VCS_b4",   bus.VCS_b,     1);
        tick();
        checkOutput("wr_no_reissue", bus.VCS_b, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h045, 16'h00A5);
        tick();
        checkOutput("wr_dtack_rel", bus.VRDTACK_b, 1);

        // ---------------- PF and MO simultaneous ----------------
        $display("[TB] PF and MO together");
        bus.PF_REQ = 1'b1;
        bus.MO_REQ = 1'b1;
        bus.PF_A   = 12'h010;
        bus.MO_A   = 12'h020;
        bus.VD_in  = 16'h1111;
        tick();
        checkOutput("pm_PF_ACK", bus.PF_ACK, 1);
        checkOutput("pm_MO_ACK", bus.MO_ACK, 0);
        checkOutput("pm_VA_pf",  bus.VA,     12'h010);
        checkOutput("pm_VOE_b",  bus.VOE_b,  0);
        bus.PF_REQ = 1'b0;
        tick();
        checkOutput("pm_PF_ACK_pulse", bus.PF_ACK, 0);
        tick(3);
        checkOutput("pm_PF_VALID", bus.PF_VALID, 1);
        checkOutput("pm_V_DATA_pf", bus.V_DATA,  16'h1111);
        checkOutput("pm_MO_ACK2",  bus.MO_ACK,   1);
        checkOutput("pm_VA_mo",    bus.VA,       12'h020);
        checkOutput("pm_no_gap",   bus.VCS_b,    0);
        checkOutput("pm_MO_VALID_early", bus.MO_VALID, 0);
        bus.MO_REQ = 1'b0;
        bus.VD_in  = 16'h2222;
        tick();
        checkOutput("pm_PF_VALID_pulse", bus.PF_VALID, 0);
        checkOutput("pm_MO_ACK_pulse",   bus.MO_ACK,   0);
        tick(3);
        checkOutput("pm_MO_VALID",  bus.MO_VALID, 1);
        checkOutput("pm_V_DATA_mo", bus.V_DATA,   16'h2222);
        checkOutput("pm_idle",      bus.VCS_b,    1);
        tick();
        checkOutput("pm_MO_VALID_pulse", bus.MO_VALID, 0);

        // ---------------- starvation guard ----------------
        $display("[TB] starvation guard");
        bus.PF_REQ = 1'b1;
        bus.PF_A   = 12'h011;
        bus.VD_in  = 16'h5A5A;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h077, 16'h0000);
        tick();
        checkOutput("st_g1_PF_ACK", bus.PF_ACK, 1);
        checkOutput("st_g1_VA",     bus.VA,     12'h011);
        tick(4);
        checkOutput("st_g2_PF_ACK", bus.PF_ACK, 1);
        checkOutput("st_g2_VA",     bus.VA,     12'h011);
        tick(4);
        checkOutput("st_g3_PF_ACK", bus.PF_ACK, 0);
        checkOutput("st_g3_VA_cpu", bus.VA,     12'h077);
        checkOutput("st_g3_VOE_b",  bus.VOE_b,  0);
        tick(4);
        checkOutput("st_cpu_dtack",  bus.VRDTACK_b, 0);
        checkOutput("st_cpu_data",   bus.CPU_D_out, 16'h5A5A);
        checkOutput("st_pf_resume",  bus.PF_ACK,    1);
        checkOutput("st_pf_VA",      bus.VA,        12'h011);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h077, 16'h0000);
        bus.PF_REQ = 1'b0;
        tick();
        checkOutput("st_dtack_rel", bus.VRDTACK_b, 1);
        tick(3);
        checkOutput("st_pf_VALID", bus.PF_VALID, 1);
        checkOutput("st_idle",     bus.VCS_b,    1);

        // ---------------- CPU abort mid-write ----------------
        $display("[TB] CPU abort");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 16'h1234);
        tick();
        checkOutput("ab_VWE_b_c0", bus.VWE_b, 0);
        tick();
        checkOutput("ab_VWE_b_c1", bus.VWE_b, 0);
        tick();
        checkOutput("ab_VWE_b_c2", bus.VWE_b, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0AA, 16'h1234);
        tick();
        checkOutput("ab_VWE_b_c3", bus.VWE_b, 3);
        checkOutput("ab_VCS_b_c3", bus.VCS_b, 0);
        tick();
        checkOutput("ab_no_dtack", bus.VRDTACK_b, 1);
        checkOutput("ab_idle",     bus.VCS_b,     1);
        tick();
        checkOutput("ab_no_dtack2", bus.VRDTACK_b, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0BB, 16'h0000);
        bus.VD_in = 16'hCAFE;
        tick();
        checkOutput("ab_new_VA",   bus.VA,    12'h0BB);
        checkOutput("ab_new_VOE",  bus.VOE_b, 0);
        tick(4);
        checkOutput("ab_new_dtack", bus.VRDTACK_b, 0);
        checkOutput("ab_new_data",  bus.CPU_D_out, 16'hCAFE);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0BB, 16'h0000);
        tick();
        checkOutput("ab_new_rel", bus.VRDTACK_b, 1);

        // ---------------- reset mid-access ----------------
        $display("[TB] reset during MO read");
        bus.MO_REQ = 1'b1;
        bus.MO_A   = 12'h033;
        bus.VD_in  = 16'h7777;
        tick();
        checkOutput("rs_MO_ACK", bus.MO_ACK, 1);
        checkOutput("rs_VOE_b",  bus.VOE_b,  0);
        bus.MO_REQ = 1'b0;
        tick(2);
        SYSRES = 1'b1;
        #1;
        checkOutput("rs_async_VCS_b", bus.VCS_b, 1);
        checkOutput("rs_async_VOE_b", bus.VOE_b, 1);
        #1;
        SYSRES = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rs_no_MO_VALID_%0d", i), bus.MO_VALID, 0);
            checkOutput($sformatf("rs_idle_%0d", i),        bus.VCS_b,    1);
        end
        bus.PF_REQ = 1'b1;
        bus.PF_A   = 12'h044;
        bus.VD_in  = 16'h4444;
        tick();
        checkOutput("rs_pf_ACK", bus.PF_ACK, 1);
        checkOutput("rs_pf_VA",  bus.VA,     12'h044);
        bus.PF_REQ = 1'b0;
        tick(4);
        checkOutput("rs_pf_VALID", bus.PF_VALID, 1);
        checkOutput("rs_pf_data",  bus.V_DATA,   16'h4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
